// File: rtl/imem_arbiter.sv
// Instruction-memory arbiter: fetch vs. loader, with loader lock.
// Optional starvation guard compiled in by IMEM_ARB_STARVE_EN.
module imem_arbiter #(
    parameter int ADDR_W   = 32,
    parameter int MAX_WAIT = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              f_req_valid,
    output logic              f_req_ready,
    input  logic [ADDR_W-1:0] f_addr,
    output logic              f_rsp_valid,
    output logic [31:0]       f_rsp_data,
    input  logic              l_req_valid,
    output logic              l_req_ready,
    input  logic              l_we,
    input  logic [ADDR_W-1:0] l_addr,
    input  logic [31:0]       l_wdata,
    input  logic              l_lock,
    output logic              l_rsp_valid,
    output logic [31:0]       l_rsp_data,
    output logic              m_en,
    output logic              m_we,
    output logic [ADDR_W-1:0] m_addr,
    output logic [31:0]       m_wdata,
    input  logic [31:0]       m_rdata
);

    typedef enum logic {IDLE, LOCKED} state_t;

    state_t state, state_n;
    logic   f_acc, l_acc, starve;
    logic   rsp_f, rsp_l;

    if (MAX_WAIT < 1 || MAX_WAIT > 255) begin : g_bad_wait
        $error("imem_arbiter: MAX_WAIT must be 1..255");
    end

`ifdef IMEM_ARB_STARVE_EN
    localparam logic [7:0] WAIT_LIM = 8'(MAX_WAIT);
    logic [7:0] wait_cnt;

    always_ff @(posedge clk) begin
        if (rst)
            wait_cnt <= '0;
        else if (!f_req_valid || f_acc)
            wait_cnt <= '0;
        else if (wait_cnt != 8'hff)
            wait_cnt <= wait_cnt + 8'd1;
    end

    assign starve = f_req_valid && (wait_cnt >= WAIT_LIM);
`else
    assign starve = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            rsp_f <= 1'b0;
            rsp_l <= 1'b0;
        end else begin
            state <= state_n;
            rsp_f <= f_acc;
            rsp_l <= l_acc;
        end
    end

    // A starved fetch borrows one slot; a held lock survives it.
    always_comb begin
        f_acc   = 1'b0;
        l_acc   = 1'b0;
        state_n = state;
        if (!rst) begin
            if (starve)
                f_acc = 1'b1;
            else if (l_req_valid)
                l_acc = 1'b1;
            else if (state == IDLE)
                f_acc = f_req_valid;
            unique case (state)
                IDLE:
                    if (l_acc && l_lock)
                        state_n = LOCKED;
                LOCKED:
                    if (!l_req_valid || (l_acc && !l_lock))
                        state_n = IDLE;
            endcase
        end
    end

    assign f_req_ready = f_acc;
    assign l_req_ready = l_acc;
    assign m_en        = f_acc | l_acc;
    assign m_we        = l_acc & l_we;
    assign m_addr      = l_acc ? l_addr : f_addr;
    assign m_wdata     = l_wdata;

    assign f_rsp_valid = rsp_f & ~rst;
    assign l_rsp_valid = rsp_l & ~rst;
    assign f_rsp_data  = m_rdata;
    assign l_rsp_data  = m_rdata;

endmodule

// File: tb/tb_imem_arbiter.sv
// Directed bench for imem_arbiter with a 1-cycle-latency memory model.
// Works with or without IMEM_ARB_STARVE_EN (MAX_WAIT=8).
module tb_imem_arbiter;

`ifdef IMEM_ARB_STARVE_EN
    localparam bit STARVE = 1'b1;
`else
    localparam bit STARVE = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst;
    logic        f_req_valid, f_req_ready, f_rsp_valid;
    logic [31:0] f_addr, f_rsp_data;
    logic        l_req_valid, l_req_ready, l_we, l_lock, l_rsp_valid;
    logic [31:0] l_addr, l_wdata, l_rsp_data;
    logic        m_en, m_we;
    logic [31:0] m_addr, m_wdata, m_rdata;

    logic [31:0] mem [0:63];
    int          errors = 0;
    int          checks = 0;

    imem_arbiter #(.ADDR_W(32), .MAX_WAIT(8)) dut (
        .clk(clk), .rst(rst),
        .f_req_valid(f_req_valid), .f_req_ready(f_req_ready),
        .f_addr(f_addr), .f_rsp_valid(f_rsp_valid),
        .f_rsp_data(f_rsp_data),
        .l_req_valid(l_req_valid), .l_req_ready(l_req_ready),
        .l_we(l_we), .l_addr(l_addr), .l_wdata(l_wdata),
        .l_lock(l_lock), .l_rsp_valid(l_rsp_valid),
        .l_rsp_data(l_rsp_data),
        .m_en(m_en), .m_we(m_we), .m_addr(m_addr),
        .m_wdata(m_wdata), .m_rdata(m_rdata)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (m_en) begin
            if (m_we)
                mem[m_addr[7:2]] <= m_wdata;
            m_rdata <= mem[m_addr[7:2]];
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic idle_inputs();
        f_req_valid = 0; f_addr = 0;
        l_req_valid = 0; l_we = 0; l_addr = 0;
        l_wdata = 0; l_lock = 0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog expired");
        $fatal(1, "timeout");
    end

    initial begin
        for (int i = 0; i < 64; i++)
            mem[i] = 32'hA000_0000 + 32'(i);
        m_rdata = 0;
        idle_inputs();
        rst = 1;
        f_req_valid = 1;
        l_req_valid = 1;
        l_we = 1;
        tick();
        #3;
        chk("rst_f_ready", 32'(f_req_ready), 0);
        chk("rst_l_ready", 32'(l_req_ready), 0);
        chk("rst_m_en", 32'(m_en), 0);
        chk("rst_m_we", 32'(m_we), 0);
        chk("rst_f_rsp", 32'(f_rsp_valid), 0);
        chk("rst_l_rsp", 32'(l_rsp_valid), 0);
        tick();

        // fetch-only stream, first accept in first cycle out of reset
        rst = 0;
        idle_inputs();
        f_req_valid = 1; f_addr = 32'h0;
        #3;
        chk("f0_ready", 32'(f_req_ready), 1);
        chk("f0_m_en", 32'(m_en), 1);
        chk("f0_m_addr", m_addr, 32'h0);
        chk("f0_m_we", 32'(m_we), 0);
        tick();
        f_addr = 32'h4;
        #3;
        chk("f1_rsp_v", 32'(f_rsp_valid), 1);
        chk("f1_rsp_d", f_rsp_data, 32'hA000_0000);
        chk("f1_ready", 32'(f_req_ready), 1);
        tick();
        f_addr = 32'h8;
        #3;
        chk("f2_rsp_d", f_rsp_data, 32'hA000_0001);
        chk("f2_l_rsp", 32'(l_rsp_valid), 0);
        tick();
        f_req_valid = 0;
        #3;
        chk("f3_rsp_v", 32'(f_rsp_valid), 1);
        chk("f3_rsp_d", f_rsp_data, 32'hA000_0002);
        chk("f3_m_en", 32'(m_en), 0);
        tick();
        #3;
        chk("f4_rsp_v", 32'(f_rsp_valid), 0);

        // contention: loader write wins, then fetch reads same word
        tick();
        f_req_valid = 1; f_addr = 32'h10;
        l_req_valid = 1; l_we = 1;
        l_addr = 32'h10; l_wdata = 32'hDEAD_BEEF;
        #3;
        chk("c0_l_ready", 32'(l_req_ready), 1);
        chk("c0_f_ready", 32'(f_req_ready), 0);
        chk("c0_m_we", 32'(m_we), 1);
        chk("c0_m_addr", m_addr, 32'h10);
        chk("c0_m_wdata", m_wdata, 32'hDEAD_BEEF);
        tick();
        l_req_valid = 0; l_we = 0;
        #3;
        chk("c1_l_rsp", 32'(l_rsp_valid), 1);
        chk("c1_f_rsp", 32'(f_rsp_valid), 0);
        chk("c1_f_ready", 32'(f_req_ready), 1);
        chk("c1_m_we", 32'(m_we), 0);
        tick();
        f_req_valid = 0;
        #3;
        chk("c2_f_rsp", 32'(f_rsp_valid), 1);
        chk("c2_f_data", f_rsp_data, 32'hDEAD_BEEF);
        chk("c2_l_rsp", 32'(l_rsp_valid), 0);

        // loader read
        tick();
        l_req_valid = 1; l_addr = 32'h14;
        #3;
        chk("lr_ready", 32'(l_req_ready), 1);
        tick();
        l_req_valid = 0;
        #3;
        chk("lr_rsp_v", 32'(l_rsp_valid), 1);
        chk("lr_rsp_d", l_rsp_data, 32'hA000_0005);

        // lock held cycles 0-3, released by l_lock=0 at cycle 3
        tick();
        f_req_valid = 1; f_addr = 32'h24;
        l_req_valid = 1; l_we = 1; l_lock = 1;
        l_addr = 32'h20; l_wdata = 32'h1;
        for (int c = 0; c < 4; c++) begin
            if (c == 3)
                l_lock = 0;
            #3;
            chk("lk_l_ready", 32'(l_req_ready), 1);
            chk("lk_f_ready", 32'(f_req_ready), 0);
            tick();
        end
        idle_inputs();
        f_req_valid = 1; f_addr = 32'h24;
        #3;
        chk("lk4_f_ready", 32'(f_req_ready), 1);
        chk("lk4_m_addr", m_addr, 32'h24);

        // lock released by an idle loader cycle
        tick();
        idle_inputs();
        l_req_valid = 1; l_lock = 1; l_addr = 32'h30;
        #3;
        chk("li0_l_ready", 32'(l_req_ready), 1);
        tick();
        idle_inputs();
        f_req_valid = 1; f_addr = 32'h30;
        #3;
        chk("li1_f_ready", 32'(f_req_ready), 0);
        tick();
        #3;
        chk("li2_f_ready", 32'(f_req_ready), 1);

        // continuous unlocked loader traffic against a waiting fetch
        tick();
        idle_inputs();
        tick();
        f_req_valid = 1; f_addr = 32'h8;
        l_req_valid = 1; l_we = 1;
        l_addr = 32'h3C; l_wdata = 32'h55;
        for (int i = 0; i < 10; i++) begin
            #3;
            chk("sv_f_ready", 32'(f_req_ready),
                32'(STARVE && i == 8));
            chk("sv_l_ready", 32'(l_req_ready),
                32'(!(STARVE && i == 8)));
            chk("sv_m_we", 32'(m_we), 32'(!(STARVE && i == 8)));
            tick();
        end

        // reset mid-operation: lock transfer, then reset
        idle_inputs();
        tick();
        l_req_valid = 1; l_lock = 1; l_addr = 32'h4;
        #3;
        chk("rm0_l_ready", 32'(l_req_ready), 1);
        tick();
        rst = 1;
        idle_inputs();
        #3;
        chk("rm1_l_rsp", 32'(l_rsp_valid), 0);
        chk("rm1_m_en", 32'(m_en), 0);
        tick();
        rst = 0;
        f_req_valid = 1; f_addr = 32'hC;
        #3;
        chk("rm2_l_rsp", 32'(l_rsp_valid), 0);
        chk("rm2_f_ready", 32'(f_req_ready), 1);
        tick();
        f_req_valid = 0;
        #3;
        chk("rm3_f_data", f_rsp_data, 32'hA000_0003);

        // fetch accepted, reset in the response cycle
        tick();
        f_req_valid = 1; f_addr = 32'h0;
        #3;
        chk("rf0_f_ready", 32'(f_req_ready), 1);
        tick();
        rst = 1;
        f_req_valid = 0;
        #3;
        chk("rf1_f_rsp", 32'(f_rsp_valid), 0);
        tick();
        rst = 0;
        #3;
        chk("rf2_f_rsp", 32'(f_rsp_valid), 0);
        tick();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
